// File: rtl/uart_tx_arb_if.sv
// Byte-stream bundle between N_REQ requesters, the round-robin arbiter and uart_tx.
// The master modport is the arbiter's view; the slave modport is the surrounding logic.
interface uart_tx_arb_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_vld_i;
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [N_REQ-1:0]   req_rdy_o;
  logic               uart_tx_data_vld_o;
  logic [7:0]         uart_tx_data_o;
  logic               uart_tx_data_rdy_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;

  modport master (
    input  req_vld_i, req_data_i, req_last_i, uart_tx_data_rdy_i,
    output req_rdy_o, uart_tx_data_vld_o, uart_tx_data_o, grant_o, busy_o
  );

  modport slave (
    output req_vld_i, req_data_i, req_last_i, uart_tx_data_rdy_i,
    input  req_rdy_o, uart_tx_data_vld_o, uart_tx_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one uart_tx byte channel between N_REQ sources.
// A grant is held until the last byte or MAX_BURST bytes (0 = unlimited) are accepted.
module uart_tx_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  uart_tx_arb_if.master bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW:0] BURST_LIM = (CW+1)'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q;
  logic [IW-1:0]    g_q;
  logic [IW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;

  logic [IW-1:0]    win_c;
  int unsigned      idx_c;
  logic             xfer_c;
  logic [CW:0]      cnt_inc_c;
  logic             lim_hit_c;
  logic             release_c;
  logic [7:0]       req_byte [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign req_byte[k] = bus.req_data_i[8*k +: 8];
  end

  // Round-robin pick: scan downward so the lowest offset from ptr+1 wins.
  always_comb begin
    win_c = '0;
    idx_c = 0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx_c = (32'(ptr_q) + i) % N_REQ;
      if (bus.req_vld_i[IW'(idx_c)]) begin
        win_c = IW'(idx_c);
      end
    end
  end

  assign xfer_c    = (state_q == GRANT) && bus.req_vld_i[g_q] && bus.uart_tx_data_rdy_i;
  assign cnt_inc_c = {1'b0, cnt_q} + (CW+1)'(1);
  assign lim_hit_c = (MAX_BURST != 0) && (cnt_inc_c == BURST_LIM);
  assign release_c = xfer_c && (bus.req_last_i[g_q] || lim_hit_c);

  // Data path is a pure passthrough of the granted requester; grant_q is zero while idle.
  assign bus.req_rdy_o          = grant_q & {N_REQ{bus.uart_tx_data_rdy_i}};
  assign bus.uart_tx_data_vld_o = |(grant_q & bus.req_vld_i);
  assign bus.uart_tx_data_o     = busy_q ? req_byte[g_q] : 8'h00;
  assign bus.grant_o            = grant_q;
  assign bus.busy_o             = busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_vld_i) begin
            state_q <= GRANT;
            g_q     <= win_c;
            cnt_q   <= '0;
            grant_q <= N_REQ'(1) << win_c;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (release_c) begin
            state_q <= IDLE;
            ptr_q   <= g_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (xfer_c) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (N_REQ=4, MAX_BURST=4): requester models, scoreboard of
// expected output bytes, and a cycle model of grant/busy/ready behaviour.
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic clk;
  logic rst_n;

  uart_tx_arb_if #(.N_REQ(N)) bus ();

  uart_tx_arb #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       push;
    logic [7:0] d;
    logic       last;
    logic       e_busy;
    logic [3:0] e_grant;
    logic       e_vld;
    logic [7:0] e_data;
  } vec_t;

  logic [8:0] srcq [N][$];
  exp_t       exp_q [$];
  logic [N-1:0] hold;
  logic       rdy_next;
  logic       rst_next;
  int         n_vec;
  int         n_err;
  logic       m_busy;
  int         m_g;
  int         m_ptr;
  int         m_cnt;
  logic       xp;
  int         xp_src;
  vec_t       tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    int r;
    int idx;
    r = -1;
    for (int i = 1; i <= N; i++) begin
      idx = (ptr + i) % N;
      if (r < 0 && v[2'(idx)]) r = idx;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = N - 1;
    m_cnt  = 0;
    xp     = 1'b0;
  endtask

  task automatic apply();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    if (xp) void'(srcq[2'(xp_src)].pop_front());
    xp = 1'b0;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (srcq[2'(k)].size() != 0) begin
        v[2'(k)]   = !hold[2'(k)];
        l[2'(k)]   = srcq[2'(k)][0][8];
        d[8*k +: 8] = srcq[2'(k)][0][7:0];
      end
    end
    bus.req_vld_i          = v;
    bus.req_last_i         = l;
    bus.req_data_i         = d;
    bus.uart_tx_data_rdy_i = rdy_next;
    rst_n                  = rst_next;
  endtask

  task automatic monitor();
    logic [N-1:0] eg;
    exp_t         e;
    if (!rst_n) begin
      chk("reset_outputs", {bus.busy_o, bus.uart_tx_data_vld_o, bus.grant_o, bus.req_rdy_o}, 0);
      model_reset();
      return;
    end
    eg = m_busy ? (N'(1) << m_g) : '0;
    chk("grant", bus.grant_o, eg);
    chk("busy", bus.busy_o, m_busy);
    chk("rdy_mirror", bus.req_rdy_o, eg & {N{bus.uart_tx_data_rdy_i}});
    chk("vld_out", bus.uart_tx_data_vld_o, m_busy && bus.req_vld_i[2'(m_g)]);
    if (!m_busy) begin
      if (|bus.req_vld_i) begin
        m_g    = pick(m_ptr, bus.req_vld_i);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (bus.req_vld_i[2'(m_g)] && bus.uart_tx_data_rdy_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h from req %0d, none expected", bus.uart_tx_data_o, m_g);
      end else begin
        e = exp_q.pop_front();
        chk("byte_data", bus.uart_tx_data_o, e.d);
        chk("byte_src", m_g, e.src);
      end
      xp     = 1'b1;
      xp_src = m_g;
      m_cnt++;
      if (bus.req_last_i[2'(m_g)] || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_ptr  = m_g;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    monitor();
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic last);
    srcq[2'(src)].push_back({last, d});
  endtask

  task automatic expect_byte(input int src, input logic [7:0] d);
    exp_q.push_back({2'(src), d});
  endtask

  task automatic wait_done();
    int c;
    logic pend;
    c = 0;
    pend = 1'b1;
    while (pend && c < 3000) begin
      step();
      c++;
      pend = (exp_q.size() != 0) || m_busy;
      for (int k = 0; k < N; k++) if (srcq[2'(k)].size() != 0) pend = 1'b1;
    end
    n_vec++;
    if (pend) begin
      n_err++;
      $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), c);
    end
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    step();
    step();
    rst_next = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    hold = '0;
    rdy_next = 1'b1;
    rst_next = 1'b0;
    rst_n = 1'b0;
    bus.req_vld_i = '0;
    bus.req_last_i = '0;
    bus.req_data_i = '0;
    bus.uart_tx_data_rdy_i = 1'b1;
    model_reset();

    // Single requester, then two one-byte packets to show re-grant after one idle cycle.
    tbl[0] = '{1'b1, 8'h61, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h62, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h61};
    tbl[2] = '{1'b1, 8'h63, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h62};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h63};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 8'h70, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 8'h71, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h70};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h71};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].push) begin
        push(0, tbl[i].d, tbl[i].last);
        expect_byte(0, tbl[i].d);
      end
      step();
      chk("tbl_busy", bus.busy_o, tbl[i].e_busy);
      chk("tbl_grant", bus.grant_o, tbl[i].e_grant);
      chk("tbl_vld", bus.uart_tx_data_vld_o, tbl[i].e_vld);
      if (tbl[i].e_vld) chk("tbl_data", bus.uart_tx_data_o, tbl[i].e_data);
    end
    wait_done();

    // Contention from reset: requester 0 first, then 1, then 2.
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    expect_byte(0, 8'hA0); expect_byte(0, 8'hA1);
    expect_byte(1, 8'hB0); expect_byte(1, 8'hB1);
    expect_byte(2, 8'hC0); expect_byte(2, 8'hC1);
    wait_done();

    // Burst cap of 4: requester 3 is split around requester 1's packet.
    for (int i = 0; i < 10; i++) push(3, 8'(i), i == 9);
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b1);
    for (int i = 0; i < 4; i++) expect_byte(3, 8'(i));
    expect_byte(1, 8'h51); expect_byte(1, 8'h52);
    for (int i = 4; i < 10; i++) expect_byte(3, 8'(i));
    wait_done();

    // Backpressure: ready toggles every 100 cycles with a second requester pending.
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    push(2, 8'h41, 1'b1);
    expect_byte(1, 8'h31); expect_byte(1, 8'h32); expect_byte(1, 8'h33);
    expect_byte(2, 8'h41);
    for (int c = 0; c < 400; c++) begin
      rdy_next = ((c / 100) % 2) == 1;
      step();
    end
    rdy_next = 1'b1;
    wait_done();

    // Lock: requester 2 drops valid mid-packet; requester 0 must wait.
    push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b0); push(2, 8'h83, 1'b1);
    expect_byte(2, 8'h81); expect_byte(2, 8'h82); expect_byte(2, 8'h83);
    expect_byte(0, 8'h90);
    step();
    step();
    hold[2] = 1'b1;
    push(0, 8'h90, 1'b1);
    for (int c = 0; c < 50; c++) begin
      step();
      chk("lock_grant", bus.grant_o, 4'b0100);
    end
    hold[2] = 1'b0;
    wait_done();

    // Reset during the second of three bytes; requester 0 wins again afterwards.
    push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    expect_byte(0, 8'h11); expect_byte(0, 8'h12);
    step();
    step();
    push(1, 8'h21, 1'b1);
    step();
    chk("pre_reset_data", bus.uart_tx_data_o, 8'h12);
    #1;
    rst_n = 1'b0;
    rst_next = 1'b0;
    #1;
    chk("midpkt_reset_outputs",
        {bus.busy_o, bus.uart_tx_data_vld_o, bus.uart_tx_data_o, bus.grant_o, bus.req_rdy_o}, 0);
    model_reset();
    exp_q.delete();
    expect_byte(0, 8'h12); expect_byte(0, 8'h13); expect_byte(1, 8'h21);
    rst_next = 1'b1;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
